// File: rtl/wb_spram_pipe.sv
// rtl/wb_spram_pipe.sv - Wishbone B4 pipelined single-port RAM slave
// Fixed-latency response pipeline, periodic stall, err on out-of-range, flush on cyc drop.
module wb_spram_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int SIZE         = 'h10000,
    parameter int LATENCY      = 1,
    parameter int STALL_PERIOD = 0,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cyc,
    input  logic                    stb,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   adr,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    ack,
    output logic                    err,
    output logic                    stall
);

    localparam int NB      = DATA_WIDTH / 8;
    localparam int DEPTH   = SIZE / NB;
    localparam int AW      = $clog2(SIZE);
    localparam int OFS_W   = $clog2(NB);
    localparam int IW      = (AW > OFS_W) ? AW - OFS_W : 1;
    localparam int SCW     = $clog2(STALL_PERIOD) + 1;
    localparam int SLAST_I = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;
    localparam logic [SCW-1:0] SLAST = SLAST_I[SCW-1:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]         idx;
    logic                  oor;
    logic                  unused_adr_bits;
    logic                  accept;
    logic                  wr_en;

    logic [SCW-1:0]        scnt_q, scnt_d;
    logic [LATENCY-1:0]    pv_q, pv_d;
    logic [LATENCY-1:0]    pe_q, pe_d;
    logic [DATA_WIDTH-1:0] pdat_q [LATENCY];
    logic [DATA_WIDTH-1:0] pdat_d [LATENCY];

    generate
        if (AW > OFS_W) begin : g_idx
            assign idx = adr[AW-1:OFS_W];
        end else begin : g_idx0
            assign idx = '0;
        end
        if (ADDR_WIDTH > AW) begin : g_oor
            assign oor = |adr[ADDR_WIDTH-1:AW];
        end else begin : g_oor0
            assign oor = 1'b0;
        end
        if (OFS_W > 0) begin : g_ofs
            assign unused_adr_bits = ^adr[OFS_W-1:0];
        end else begin : g_ofs0
            assign unused_adr_bits = 1'b0;
        end
    endgenerate

    assign stall  = (STALL_PERIOD != 0) && cyc && (scnt_q == SLAST);
    assign accept = cyc & stb & ~stall;
    assign wr_en  = accept & we & ~oor;

    always_comb begin
        scnt_d = scnt_q + SCW'(1);
        if (!cyc || (STALL_PERIOD == 0) || (scnt_q == SLAST)) begin
            scnt_d = '0;
        end
    end

    // Stage 0 captures the read word at acceptance; later stages just shift.
    // Dropping cyc kills every in-flight response.
    always_comb begin
        pv_d      = '0;
        pe_d      = '0;
        pdat_d[0] = (accept && !we && !oor) ? mem[idx] : '0;
        pv_d[0]   = accept;
        pe_d[0]   = oor;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i]   = cyc & pv_q[i-1];
            pe_d[i]   = pe_q[i-1];
            pdat_d[i] = pdat_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q <= '0;
            pv_q   <= '0;
            pe_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pdat_q[i] <= '0;
            end
        end else begin
            scnt_q <= scnt_d;
            pv_q   <= pv_d;
            pe_q   <= pe_d;
            for (int i = 0; i < LATENCY; i++) begin
                pdat_q[i] <= pdat_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (sel[i]) begin
                    mem[idx][i*8 +: 8] <= dat_i[i*8 +: 8];
                end
            end
        end
    end

    assign ack   = cyc & pv_q[LATENCY-1] & ~pe_q[LATENCY-1];
    assign err   = cyc & pv_q[LATENCY-1] & pe_q[LATENCY-1];
    assign dat_o = ack ? pdat_q[LATENCY-1] : '0;

endmodule
